// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit, common-anode
//               seven-segment display. Presents one hex nibble at a time to
//               an external decoder7, drives the matching active-low anode,
//               inserts an all-off guard interval between digits and pulses
//               frame after each complete 4-digit scan.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int DIV   = 4096,   // SHOW cycles per digit, 1..65535
    parameter int GUARD = 16      // all-off cycles between digits, 0..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  blank,
    output logic [3:0]  X,
    output logic [3:0]  an,
    output logic [1:0]  digit,
    output logic        frame
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_show  = 2'd1;
    localparam logic [1:0] c_st_guard = 2'd2;

    localparam logic [15:0] c_div_last   = 16'(DIV - 1);
    // With GUARD=0 the guard state is never entered, so this value is unused
    // in practice; it is clamped to keep the constant in range.
    localparam logic [15:0] c_guard_last = 16'((GUARD > 0) ? (GUARD - 1) : 0);
    localparam bit          c_no_guard   = (GUARD == 0);
    localparam logic [3:0]  c_an_off     = 4'b1111;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_data_q;
    logic [3:0]  r_x;
    logic [3:0]  r_an;
    logic [1:0]  r_digit;
    logic        r_frame;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [15:0] w_nxt;        // shadow data with same-cycle load forwarded
    logic [1:0]  w_digit_inc;  // next digit index, wraps 3 -> 0
    logic [3:0]  w_x_inc;      // nibble for the next digit
    logic [3:0]  w_an_cur;     // anode pattern for the current digit
    logic [3:0]  w_an_inc;     // anode pattern for the next digit

    // Active-low anode pattern: only the selected digit may be driven low,
    // and only when its blank bit is clear.
    function automatic logic [3:0] f_an_mask(input logic [1:0] d,
                                             input logic [3:0] b);
        logic [3:0] m;
        m    = c_an_off;
        m[d] = b[d];
        return m;
    endfunction

    // Forwarding and next-digit selection used by every SHOW entry
    always_comb begin
        w_nxt       = load ? din : r_data_q;
        w_digit_inc = r_digit + 2'd1;
        w_x_inc     = w_nxt[{w_digit_inc, 2'b00} +: 4];
        w_an_cur    = f_an_mask(r_digit, blank);
        w_an_inc    = f_an_mask(w_digit_inc, blank);
    end

    // Scan FSM, phase counter, shadow register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= 16'd0;
            r_data_q <= 16'd0;
            r_x      <= 4'd0;
            r_an     <= c_an_off;
            r_digit  <= 2'd0;
            r_frame  <= 1'b0;
        end else begin
            if (load) begin
                r_data_q <= din;
            end

            // frame is a single-cycle pulse; only the digit-3 SHOW exit sets it
            r_frame <= 1'b0;

            if (!en) begin
                // Disabling always returns to a clean start-of-frame point
                r_state <= c_st_idle;
                r_an    <= c_an_off;
                r_digit <= 2'd0;
                r_cnt   <= 16'd0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        r_state <= c_st_show;
                        r_digit <= 2'd0;
                        r_cnt   <= 16'd0;
                        r_x     <= w_nxt[3:0];
                        r_an    <= f_an_mask(2'd0, blank);
                    end

                    c_st_show: begin
                        if (r_cnt == c_div_last) begin
                            r_cnt   <= 16'd0;
                            r_frame <= (r_digit == 2'd3);
                            if (c_no_guard) begin
                                // Back-to-back digits: step straight on
                                r_digit <= w_digit_inc;
                                r_x     <= w_x_inc;
                                r_an    <= w_an_inc;
                            end else begin
                                r_state <= c_st_guard;
                                r_an    <= c_an_off;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                            r_an  <= w_an_cur;
                        end
                    end

                    c_st_guard: begin
                        if (r_cnt == c_guard_last) begin
                            r_state <= c_st_show;
                            r_cnt   <= 16'd0;
                            r_digit <= w_digit_inc;
                            r_x     <= w_x_inc;
                            r_an    <= w_an_inc;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end

                    default: begin
                        r_state <= c_st_idle;
                        r_an    <= c_an_off;
                        r_digit <= 2'd0;
                        r_cnt   <= 16'd0;
                    end
                endcase
            end
        end
    end

    assign X     = r_x;
    assign an    = r_an;
    assign digit = r_digit;
    assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed bench for seg_scan_ctrl. Expected output words are
//               queued as stimulus is applied and popped one per clock.
//               Instance dut uses DIV=4/GUARD=1, instance dut0 DIV=4/GUARD=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] an;
        logic [1:0] digit;
        logic       frame;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DIV=4, GUARD=1 instance
    logic        rst, en, load;
    logic [15:0] din;
    logic [3:0]  blank;
    logic [3:0]  x1, an1;
    logic [1:0]  dig1;
    logic        frm1;

    // DIV=4, GUARD=0 instance
    logic        rst0, en0, load0;
    logic [15:0] din0;
    logic [3:0]  blank0;
    logic [3:0]  x0, an0;
    logic [1:0]  dig0;
    logic        frm0;

    seg_scan_ctrl #(.DIV(4), .GUARD(1)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .blank(blank),
        .X(x1), .an(an1), .digit(dig1), .frame(frm1)
    );

    seg_scan_ctrl #(.DIV(4), .GUARD(0)) dut0 (
        .clk(clk), .rst(rst0), .en(en0), .load(load0), .din(din0), .blank(blank0),
        .X(x0), .an(an0), .digit(dig0), .frame(frm0)
    );

    obs_t obs1, obs0;
    assign obs1 = {x1, an1, dig1, frm1};
    assign obs0 = {x0, an0, dig0, frm0};

    obs_t  q1[$], q0[$];
    string t1[$], t0[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed X=%h an=%b digit=%0d frame=%b, expected X=%h an=%b digit=%0d frame=%b",
                   tag, got.x, got.an, got.digit, got.frame,
                   exp.x, exp.an, exp.digit, exp.frame);
        end
    endtask

    task automatic push(input bit sel, input logic [3:0] x, input logic [3:0] a,
                        input logic [1:0] d, input logic f, input string tag);
        obs_t e;
        e = {x, a, d, f};
        if (sel) begin q1.push_back(e); t1.push_back(tag); end
        else     begin q0.push_back(e); t0.push_back(tag); end
    endtask

    // n SHOW cycles of digit k presenting nibble x
    task automatic push_show(input bit sel, input logic [3:0] x, input logic [1:0] k,
                             input int n, input bit blanked, input string tag);
        logic [3:0] a;
        a = blanked ? 4'b1111 : ~(4'b0001 << k);
        for (int i = 0; i < n; i++) push(sel, x, a, k, 1'b0, tag);
    endtask

    task automatic push_guard(input logic [3:0] x, input logic [1:0] k,
                              input logic f, input string tag);
        push(1'b1, x, 4'b1111, k, f, tag);
    endtask

    // One complete 20-cycle frame on dut
    task automatic push_frame(input logic [15:0] v, input logic [3:0] bmask,
                              input string tag);
        for (int k = 0; k < 4; k++) begin
            push_show(1'b1, v[4*k +: 4], 2'(k), 4, bmask[k], tag);
            push_guard(v[4*k +: 4], 2'(k), (k == 3), tag);
        end
    endtask

    // Advance n clocks, comparing one queued word per instance per clock
    task automatic tick(input int n);
        obs_t  e;
        string t;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front(); t = t1.pop_front();
                check(t, obs1, e);
            end
            if (q0.size() > 0) begin
                e = q0.pop_front(); t = t0.pop_front();
                check(t, obs0, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; din = 16'h0000; blank = 4'b0000;
        rst0 = 1'b1; en0 = 1'b0; load0 = 1'b0; din0 = 16'h0000; blank0 = 4'b0000;

        // Reset state
        push(1'b1, 4'h0, 4'b1111, 2'd0, 1'b0, "reset");
        push(1'b1, 4'h0, 4'b1111, 2'd0, 1'b0, "reset");
        tick(2);

        // Load + enable in the same cycle, one full frame then the wrap
        rst = 1'b0; load = 1'b1; din = 16'h4321; en = 1'b1;
        push_frame(16'h4321, 4'b0000, "frame1");
        push_show(1'b1, 4'h1, 2'd0, 4, 1'b0, "wrap");
        tick(1);
        load = 1'b0;
        tick(23);

        // Digit 2 blanked for the rest of this frame
        blank = 4'b0100;
        push_guard(4'h1, 2'd0, 1'b0, "blank");
        push_show(1'b1, 4'h2, 2'd1, 4, 1'b0, "blank");
        push_guard(4'h2, 2'd1, 1'b0, "blank");
        push_show(1'b1, 4'h3, 2'd2, 4, 1'b1, "blank_d2");
        push_guard(4'h3, 2'd2, 1'b0, "blank");
        push_show(1'b1, 4'h4, 2'd3, 4, 1'b0, "blank");
        push_guard(4'h4, 2'd3, 1'b1, "blank_frame");
        tick(16);
        blank = 4'b0000;

        // New data loaded mid-SHOW of digit 1
        push_show(1'b1, 4'h1, 2'd0, 4, 1'b0, "midload");
        push_guard(4'h1, 2'd0, 1'b0, "midload");
        push_show(1'b1, 4'h2, 2'd1, 2, 1'b0, "midload");
        tick(7);
        load = 1'b1; din = 16'hABCD;
        push_show(1'b1, 4'h2, 2'd1, 1, 1'b0, "midload_hold");
        tick(1);
        load = 1'b0;
        push_show(1'b1, 4'h2, 2'd1, 1, 1'b0, "midload_hold");
        push_guard(4'h2, 2'd1, 1'b0, "midload_hold");
        push_show(1'b1, 4'hB, 2'd2, 4, 1'b0, "midload_d2");
        push_guard(4'hB, 2'd2, 1'b0, "midload");
        push_show(1'b1, 4'hA, 2'd3, 4, 1'b0, "midload_d3");
        push_guard(4'hA, 2'd3, 1'b1, "midload_frame");
        tick(12);

        // Enable dropped during GUARD, re-raised after three cycles
        push_show(1'b1, 4'hD, 2'd0, 4, 1'b0, "endrop");
        tick(4);
        push_guard(4'hD, 2'd0, 1'b0, "endrop");
        tick(1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b1, 4'hD, 4'b1111, 2'd0, 1'b0, "en_gap");
        tick(3);
        en = 1'b1;
        push_show(1'b1, 4'hD, 2'd0, 4, 1'b0, "restart");
        push_guard(4'hD, 2'd0, 1'b0, "restart");
        push_show(1'b1, 4'hC, 2'd1, 4, 1'b0, "restart");
        tick(9);

        // Reset wins over load and en; shadow register cleared
        rst = 1'b1; load = 1'b1; din = 16'hFFFF;
        push(1'b1, 4'h0, 4'b1111, 2'd0, 1'b0, "rst_prio");
        tick(1);
        rst = 1'b0; load = 1'b0;
        push_show(1'b1, 4'h0, 2'd0, 1, 1'b0, "rst_data_cleared");
        tick(1);
        en = 1'b0;
        push(1'b1, 4'h0, 4'b1111, 2'd0, 1'b0, "idle");
        tick(1);

        // GUARD=0 instance: back-to-back digits, reset during digit-2 SHOW
        push(1'b0, 4'h0, 4'b1111, 2'd0, 1'b0, "g0_reset");
        tick(1);
        rst0 = 1'b0; load0 = 1'b1; din0 = 16'h4321; en0 = 1'b1;
        push_show(1'b0, 4'h1, 2'd0, 4, 1'b0, "g0_d0");
        tick(1);
        load0 = 1'b0;
        push_show(1'b0, 4'h2, 2'd1, 4, 1'b0, "g0_d1");
        push_show(1'b0, 4'h3, 2'd2, 2, 1'b0, "g0_d2");
        tick(9);
        rst0 = 1'b1;
        push(1'b0, 4'h0, 4'b1111, 2'd0, 1'b0, "g0_abort");
        push(1'b0, 4'h0, 4'b1111, 2'd0, 1'b0, "g0_abort");
        tick(2);

        // Every queued expectation must have been consumed
        n_checks++;
        assert (q1.size() == 0 && q0.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: observed %0d/%0d entries left, expected 0/0",
                   q1.size(), q0.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
